// File: rtl/dbg_target_pkg.sv
// dbg_target_pkg: debug-target address map, control bit positions and FSM states
package dbg_target_pkg;
  localparam int GRP_INT = 0;
  localparam int GRP_GPR = 1;
  localparam logic [11:0] REG_CTRL    = 12'h000;
  localparam logic [11:0] REG_HIT     = 12'h001;
  localparam logic [11:0] REG_NPC     = 12'h002;
  localparam logic [11:0] REG_BP_BASE = 12'h010;
  localparam int CTRL_STEP = 0;
  localparam int CTRL_BPEN = 1;
  localparam int BPC_EN    = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_e;
endpackage

// File: rtl/dbg_target_if.sv
// dbg_target_if: debug host bus, host drives the master side, target the slave side
interface dbg_target_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] wdat;
  logic [DATA_WIDTH-1:0] rdat;
  logic                  ack;
  modport master (output stb, we, adr, wdat, input rdat, ack);
  modport slave (input stb, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/dbg_bp_cmp.sv
// dbg_bp_cmp: one hardware breakpoint, enable/address register plus PC comparator
module dbg_bp_cmp
  import dbg_target_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en_i,
  input  logic                  wr_adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  en_o,
  output logic [DATA_WIDTH-1:0] adr_o,
  output logic                  match_o
);
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] adr_q, adr_d;
  // host writes to the breakpoint control and address registers
  always_comb begin
    en_d  = wr_en_i ? dat_i[BPC_EN] : en_q;
    adr_d = wr_adr_i ? dat_i : adr_q;
  end
  // breakpoint state, cleared by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q  <= 1'b0;
      adr_q <= '0;
    end else begin
      en_q  <= en_d;
      adr_q <= adr_d;
    end
  end
  assign en_o    = en_q;
  assign adr_o   = adr_q;
  assign match_o = en_q && pc_i == adr_q;
endmodule

// File: rtl/dbg_target.sv
// dbg_target: debug-bus slave with control/hit registers, hardware breakpoints, single-step and GPR access
module dbg_target
  import dbg_target_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NBP        = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  dbg_target_if.slave           dbg,
  input  logic                  dbg_stall_i,
  output logic                  dbg_bp_o,
  input  logic [DATA_WIDTH-1:0] cpu_pc_i,
  input  logic                  cpu_pc_valid_i,
  output logic [4:0]            gpr_adr_o,
  output logic                  gpr_rd_o,
  output logic                  gpr_we_o,
  output logic [DATA_WIDTH-1:0] gpr_dat_o,
  input  logic [DATA_WIDTH-1:0] gpr_dat_i
);
  localparam int GW = ADDR_WIDTH - 12;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  bp_q, bp_d;
  logic                  gpr_rd_q, gpr_rd_d;
  logic                  gpr_we_q, gpr_we_d;
  logic [4:0]            gpr_adr_q, gpr_adr_d;
  logic [DATA_WIDTH-1:0] gpr_dat_q, gpr_dat_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [NBP:0]          hit_q, hit_d;
  logic [NBP:0]          hit_set, hit_clr;
  logic [DATA_WIDTH-1:0] npc_q, npc_d;
  logic [NBP-1:0]        bp_en, bp_match, bp_wr_en, bp_wr_adr;
  logic [DATA_WIDTH-1:0] bp_adr [NBP];
  logic [DATA_WIDTH-1:0] int_rd;
  logic [11:0]           off;
  logic                  grp_int, in_gpr, accept, wr_int;
  assign off     = adr_q[11:0];
  assign grp_int = adr_q[ADDR_WIDTH-1:12] == GW'(GRP_INT);
  assign in_gpr  = dbg.adr[ADDR_WIDTH-1:12] == GW'(GRP_GPR);
  assign accept  = state_q == ST_IDLE && dbg.stb;
  assign wr_int  = state_q == ST_ACCESS && we_q && grp_int;
  for (genvar i = 0; i < NBP; i++) begin : g_bp
    localparam logic [11:0] A = REG_BP_BASE + 12'(2 * i);
    assign bp_wr_en[i]  = wr_int && off == A;
    assign bp_wr_adr[i] = wr_int && off == A + 12'd1;
    dbg_bp_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en_i  (bp_wr_en[i]),
      .wr_adr_i (bp_wr_adr[i]),
      .dat_i    (wdat_q),
      .pc_i     (cpu_pc_i),
      .en_o     (bp_en[i]),
      .adr_o    (bp_adr[i]),
      .match_o  (bp_match[i])
    );
  end
  // internal register read mux; unmapped offsets read zero
  always_comb begin
    int_rd = '0;
    if (off == REG_CTRL) int_rd = DATA_WIDTH'(ctrl_q);
    if (off == REG_HIT) int_rd = DATA_WIDTH'(hit_q);
    if (off == REG_NPC) int_rd = npc_q;
    for (int n = 0; n < NBP; n++) begin
      if (off == REG_BP_BASE + 12'(2 * n)) int_rd = DATA_WIDTH'(bp_en[n]);
      if (off == REG_BP_BASE + 12'(2 * n + 1)) int_rd = bp_adr[n];
    end
  end
  // next state: access FSM, GPR strobes, control/hit/npc registers; a hit set beats a same-cycle clear
  always_comb begin
    hit_set   = {cpu_pc_valid_i & ctrl_q[CTRL_STEP],
                 bp_match & {NBP{cpu_pc_valid_i & ctrl_q[CTRL_BPEN]}}} & {(NBP+1){~dbg_stall_i}};
    hit_clr   = wr_int && off == REG_HIT ? wdat_q[NBP:0] : '0;
    state_d   = state_q == ST_IDLE ? (dbg.stb ? ST_ACCESS : ST_IDLE) :
                state_q == ST_ACCESS ? ST_ACK : ST_IDLE;
    adr_d     = accept ? dbg.adr : adr_q;
    we_d      = accept ? dbg.we : we_q;
    wdat_d    = accept ? dbg.wdat : wdat_q;
    ack_d     = state_q == ST_ACCESS;
    rdat_d    = state_q == ST_ACCESS ? (grp_int ? int_rd : gpr_rd_q ? gpr_dat_i : '0) : rdat_q;
    gpr_rd_d  = accept && in_gpr && !dbg.we && dbg_stall_i;
    gpr_we_d  = accept && in_gpr && dbg.we && dbg_stall_i;
    gpr_adr_d = accept && in_gpr ? dbg.adr[4:0] : gpr_adr_q;
    gpr_dat_d = accept && in_gpr && dbg.we ? dbg.wdat : gpr_dat_q;
    ctrl_d    = wr_int && off == REG_CTRL ? wdat_q[1:0] : ctrl_q;
    hit_d     = (hit_q & ~hit_clr) | hit_set;
    npc_d     = |hit_set ? cpu_pc_i : npc_q;
    bp_d      = |hit_set;
  end
  // all state and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      bp_q      <= 1'b0;
      gpr_rd_q  <= 1'b0;
      gpr_we_q  <= 1'b0;
      gpr_adr_q <= '0;
      gpr_dat_q <= '0;
      ctrl_q    <= '0;
      hit_q     <= '0;
      npc_q     <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      bp_q      <= bp_d;
      gpr_rd_q  <= gpr_rd_d;
      gpr_we_q  <= gpr_we_d;
      gpr_adr_q <= gpr_adr_d;
      gpr_dat_q <= gpr_dat_d;
      ctrl_q    <= ctrl_d;
      hit_q     <= hit_d;
      npc_q     <= npc_d;
    end
  end
  assign dbg.ack   = ack_q;
  assign dbg.rdat  = rdat_q;
  assign dbg_bp_o  = bp_q;
  assign gpr_rd_o  = gpr_rd_q;
  assign gpr_we_o  = gpr_we_q;
  assign gpr_adr_o = gpr_adr_q;
  assign gpr_dat_o = gpr_dat_q;
endmodule

// File: tb/tb_dbg_target.sv
// tb_dbg_target: directed self-checking bench for dbg_target
module tb_dbg_target;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        bp;
  logic [31:0] cpu_pc = '0;
  logic        cpu_valid = 1'b0;
  logic [4:0]  gpr_adr;
  logic        gpr_rd, gpr_we;
  logic [31:0] gpr_dat_o, gpr_dat_i;
  logic [31:0] gpr_mem [32];
  int          total = 0, passed = 0;
  int          ack_n = 0, bp_n = 0, rd_n = 0, we_n = 0;
  int          a0, b0, r0, w0, lat;
  logic [31:0] r;

  dbg_target_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  dbg_target #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NBP(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .dbg            (bus),
    .dbg_stall_i    (stall),
    .dbg_bp_o       (bp),
    .cpu_pc_i       (cpu_pc),
    .cpu_pc_valid_i (cpu_valid),
    .gpr_adr_o      (gpr_adr),
    .gpr_rd_o       (gpr_rd),
    .gpr_we_o       (gpr_we),
    .gpr_dat_o      (gpr_dat_o),
    .gpr_dat_i      (gpr_dat_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (gpr_we) gpr_mem[gpr_adr] <= gpr_dat_o;
  assign gpr_dat_i = gpr_mem[gpr_adr];

  always @(negedge clk) begin
    if (bus.ack) ack_n++;
    if (bp) bp_n++;
    if (gpr_rd) rd_n++;
    if (gpr_we) we_n++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic acc(input logic w, input logic [15:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int l);
    @(negedge clk);
    bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.wdat = d;
    rd = 'x; l = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      l++;
      if (bus.ack) begin
        rd = bus.rdat;
        break;
      end
    end
    bus.stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic retire(input logic [31:0] pc);
    @(negedge clk);
    cpu_pc = pc; cpu_valid = 1'b1;
    @(negedge clk);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr_mem[i] = '0;
    bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.wdat = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_bp", 32'(bp), 0);
    chk("rst_gpr_rd", 32'(gpr_rd), 0);
    chk("rst_gpr_we", 32'(gpr_we), 0);
    chk("rst_rdat", bus.rdat, 0);
    chk("rst_gpr_adr", 32'(gpr_adr), 0);
    chk("rst_gpr_dat", gpr_dat_o, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    a0 = ack_n; acc(1'b1, 16'h0000, 32'h2, r, lat);
    chk("ctrl_wr_lat", lat, 2);
    chk("ctrl_wr_acks", ack_n - a0, 1);
    a0 = ack_n; acc(1'b0, 16'h0000, 32'h0, r, lat);
    chk("ctrl_rd_data", r, 32'h2);
    chk("ctrl_rd_lat", lat, 2);
    chk("ctrl_rd_acks", ack_n - a0, 1);

    acc(1'b1, 16'h0011, 32'h100, r, lat);
    acc(1'b1, 16'h0010, 32'h1, r, lat);
    b0 = bp_n;
    @(negedge clk); cpu_pc = 32'h100; cpu_valid = 1'b1;
    @(negedge clk); cpu_valid = 1'b0;
    chk("bp0_pulse_hi", 32'(bp), 1);
    @(negedge clk);
    chk("bp0_pulse_lo", 32'(bp), 0);
    repeat (2) @(negedge clk);
    chk("bp0_pulses", bp_n - b0, 1);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("bp0_hit", r, 32'h1);
    acc(1'b0, 16'h0002, 32'h0, r, lat);
    chk("bp0_npc", r, 32'h100);
    b0 = bp_n; retire(32'h104);
    chk("bp0_miss", bp_n - b0, 0);

    acc(1'b1, 16'h0013, 32'h100, r, lat);
    acc(1'b1, 16'h0012, 32'h1, r, lat);
    acc(1'b0, 16'h0013, 32'h0, r, lat);
    chk("bp1_adr_rd", r, 32'h100);
    acc(1'b1, 16'h0001, 32'h7, r, lat);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("hit_w1c", r, 32'h0);
    b0 = bp_n; retire(32'h100);
    chk("multi_pulses", bp_n - b0, 1);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("multi_hit", r, 32'h3);
    acc(1'b0, 16'h0003, 32'h0, r, lat);
    chk("unmapped_int", r, 32'h0);
    a0 = ack_n; acc(1'b0, 16'h2000, 32'h0, r, lat);
    chk("other_grp_data", r, 32'h0);
    chk("other_grp_acks", ack_n - a0, 1);

    @(negedge clk); bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 16'h0001; bus.wdat = 32'h3;
    @(negedge clk); cpu_pc = 32'h100; cpu_valid = 1'b1;
    @(negedge clk); cpu_valid = 1'b0;
    chk("setwin_ack", 32'(bus.ack), 1);
    bus.stb = 1'b0;
    repeat (3) @(negedge clk);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("setwin_hit", r, 32'h3);
    acc(1'b1, 16'h0001, 32'h3, r, lat);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("hit_cleared", r, 32'h0);
    acc(1'b1, 16'h0000, 32'h0, r, lat);

    stall = 1'b1;
    w0 = we_n; acc(1'b1, 16'h1005, 32'h12345678, r, lat);
    chk("gpr_we_pulses", we_n - w0, 1);
    chk("gpr_adr", 32'(gpr_adr), 5);
    chk("gpr_wdat", gpr_dat_o, 32'h12345678);
    r0 = rd_n; acc(1'b0, 16'h1005, 32'h0, r, lat);
    chk("gpr_rd_data", r, 32'h12345678);
    chk("gpr_rd_pulses", rd_n - r0, 1);

    stall = 1'b0;
    r0 = rd_n; a0 = ack_n; acc(1'b0, 16'h1005, 32'h0, r, lat);
    chk("nostall_rd_data", r, 32'h0);
    chk("nostall_rd_pulses", rd_n - r0, 0);
    chk("nostall_rd_acks", ack_n - a0, 1);
    w0 = we_n; acc(1'b1, 16'h1005, 32'hdeadbeef, r, lat);
    chk("nostall_wr_pulses", we_n - w0, 0);
    stall = 1'b1;
    acc(1'b0, 16'h1005, 32'h0, r, lat);
    chk("nostall_wr_dropped", r, 32'h12345678);

    acc(1'b1, 16'h0000, 32'h1, r, lat);
    b0 = bp_n;
    retire(32'h400); retire(32'h404); retire(32'h408);
    chk("step_stalled_pulses", bp_n - b0, 0);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("step_stalled_hit", r, 32'h0);
    stall = 1'b0;
    b0 = bp_n; retire(32'h40c);
    chk("step_pulses", bp_n - b0, 1);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("step_hit", r, 32'h4);
    acc(1'b0, 16'h0002, 32'h0, r, lat);
    chk("step_npc", r, 32'h40c);
    acc(1'b1, 16'h0001, 32'h4, r, lat);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("step_w1c", r, 32'h0);

    acc(1'b1, 16'h0000, 32'h2, r, lat);
    acc(1'b1, 16'h0011, 32'h200, r, lat);
    retire(32'h200);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("pre_rst_hit", r, 32'h1);
    a0 = ack_n;
    @(negedge clk); bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 16'h0000; bus.wdat = 32'h3;
    @(negedge clk); rstn = 1'b0; bus.stb = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_abort_acks", ack_n - a0, 0);
    chk("rst2_rdat", bus.rdat, 0);
    chk("rst2_gpr_adr", 32'(gpr_adr), 0);
    acc(1'b0, 16'h0000, 32'h0, r, lat);
    chk("rst2_ctrl", r, 32'h0);
    chk("rst2_lat", lat, 2);
    acc(1'b0, 16'h0001, 32'h0, r, lat);
    chk("rst2_hit", r, 32'h0);
    acc(1'b0, 16'h0002, 32'h0, r, lat);
    chk("rst2_npc", r, 32'h0);
    acc(1'b0, 16'h0010, 32'h0, r, lat);
    chk("rst2_bp0_ctrl", r, 32'h0);
    acc(1'b0, 16'h0011, 32'h0, r, lat);
    chk("rst2_bp0_adr", r, 32'h0);
    acc(1'b0, 16'h0013, 32'h0, r, lat);
    chk("rst2_bp1_adr", r, 32'h0);
    a0 = ack_n;
    acc(1'b1, 16'h0000, 32'h2, r, lat);
    acc(1'b0, 16'h0000, 32'h0, r, lat);
    chk("post_rst_ctrl", r, 32'h2);
    chk("post_rst_acks", ack_n - a0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
